// File: rtl/pipe_memwb_elastic.sv
// pipe_memwb_elastic
// MEM/WB pipeline stage with a valid/ready handshake and a 2-entry skid buffer.
// The writeback mux (memory data vs ALU data) is resolved when a beat is
// captured, so WB sees a single registered result. in_ready is a pure register
// output, which keeps the WB stall off any combinational path back to MEM.
//
// Ports:
//   clock, reset          stage clock, asynchronous active-low reset
//   flush                 synchronous flush, invalidates both entries
//   in_valid/in_ready     MEM-side handshake
//   memRead_dataOut_i     data memory read result
//   regData_i             ALU / pass-through result
//   mem2Reg_i             1 selects memRead_dataOut_i as the writeback value
//   regWrite_i            beat writes the register file
//   writeReg_i            destination register
//   out_valid/out_ready   WB-side handshake
//   wbData_o              resolved writeback value of the head entry
//   regWrite_o            head write enable, 0 whenever out_valid=0
//   writeReg_o            head destination register
//   fwd_valid_o           forwarding tap usable (out_valid & regWrite_o)
//   stall_cnt_o           saturating count of out_valid & !out_ready cycles
//   stall_cnt_clr         synchronous clear of stall_cnt_o
module pipe_memwb_elastic #(
    parameter int unsigned DATA_WIDTH            = 64,
    parameter int unsigned REGFILE_ADDRESS_WIDTH = 5,
    parameter int unsigned ZERO_REG_GUARD        = 1,
    parameter int unsigned STALL_CNT_WIDTH       = 16
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH-1:0]            memRead_dataOut_i,
    input  logic [DATA_WIDTH-1:0]            regData_i,
    input  logic                             mem2Reg_i,
    input  logic                             regWrite_i,
    input  logic [REGFILE_ADDRESS_WIDTH-1:0] writeReg_i,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH-1:0]            wbData_o,
    output logic                             regWrite_o,
    output logic [REGFILE_ADDRESS_WIDTH-1:0] writeReg_o,
    output logic                             fwd_valid_o,
    output logic [STALL_CNT_WIDTH-1:0]       stall_cnt_o,
    input  logic                             stall_cnt_clr
);

    localparam bit GUARD_EN = (ZERO_REG_GUARD != 0);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]            wb;
        logic                             rw;
        logic [REGFILE_ADDRESS_WIDTH-1:0] wr;
    } entry_t;

    state_t                     r_state;
    entry_t                     r_main;
    entry_t                     r_skid;
    logic                       r_out_valid;
    logic                       r_in_ready;
    logic                       r_regwrite;
    logic [STALL_CNT_WIDTH-1:0] r_stall_cnt;

    state_t w_nxt_state;
    entry_t w_nxt_main;
    entry_t w_nxt_skid;
    entry_t w_in_entry;
    logic   w_accept;
    logic   w_drain;
    logic   w_nxt_valid;
    logic   w_stall_inc;

    // Incoming beat with the writeback mux and zero-register guard resolved.
    always_comb begin
        w_in_entry    = '0;
        w_in_entry.wb = mem2Reg_i ? memRead_dataOut_i : regData_i;
        w_in_entry.rw = regWrite_i & ~(GUARD_EN & (writeReg_i == '0));
        w_in_entry.wr = writeReg_i;
    end

    assign w_accept = in_valid & r_in_ready;
    assign w_drain  = r_out_valid & out_ready;

    // Next-state and entry load selection; flush overrides everything.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_main  = r_main;
        w_nxt_skid  = r_skid;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_nxt_state = ONE;
                    w_nxt_main  = w_in_entry;
                end
            end
            ONE: begin
                if (w_accept && w_drain) begin
                    w_nxt_main = w_in_entry;
                end else if (w_accept) begin
                    w_nxt_state = FULL;
                    w_nxt_skid  = w_in_entry;
                end else if (w_drain) begin
                    w_nxt_state = EMPTY;
                end
            end
            FULL: begin
                if (w_drain) begin
                    w_nxt_state = ONE;
                    w_nxt_main  = r_skid;
                end
            end
            default: begin
                w_nxt_state = EMPTY;
            end
        endcase
        if (flush) begin
            w_nxt_state = EMPTY;
        end
    end

    assign w_nxt_valid = (w_nxt_state != EMPTY);

    // State register plus registered handshake/status outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_regwrite  <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_main      <= w_nxt_main;
            r_skid      <= w_nxt_skid;
            r_out_valid <= w_nxt_valid;
            r_in_ready  <= (w_nxt_state != FULL);
            r_regwrite  <= w_nxt_main.rw & w_nxt_valid;
        end
    end

    assign w_stall_inc = r_out_valid & ~out_ready & (r_stall_cnt != '1);

    // Saturating stall counter; clear wins, flush does not touch it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (stall_cnt_clr) begin
            r_stall_cnt <= '0;
        end else if (w_stall_inc) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_WIDTH'(1);
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign wbData_o    = r_main.wb;
    assign writeReg_o  = r_main.wr;
    assign regWrite_o  = r_regwrite;
    assign fwd_valid_o = r_regwrite;
    assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_pipe_memwb_elastic.sv
// Directed bench for pipe_memwb_elastic (stall counter reduced to 4 bits).
module tb_pipe_memwb_elastic;

    localparam int unsigned DW = 64;
    localparam int unsigned AW = 5;
    localparam int unsigned SW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] memRead_dataOut_i;
    logic [DW-1:0] regData_i;
    logic          mem2Reg_i;
    logic          regWrite_i;
    logic [AW-1:0] writeReg_i;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] wbData_o;
    logic          regWrite_o;
    logic [AW-1:0] writeReg_o;
    logic          fwd_valid_o;
    logic [SW-1:0] stall_cnt_o;
    logic          stall_cnt_clr;

    int checks   = 0;
    int failures = 0;

    pipe_memwb_elastic #(
        .DATA_WIDTH           (DW),
        .REGFILE_ADDRESS_WIDTH(AW),
        .ZERO_REG_GUARD       (1),
        .STALL_CNT_WIDTH      (SW)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .memRead_dataOut_i(memRead_dataOut_i),
        .regData_i        (regData_i),
        .mem2Reg_i        (mem2Reg_i),
        .regWrite_i       (regWrite_i),
        .writeReg_i       (writeReg_i),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .wbData_o         (wbData_o),
        .regWrite_o       (regWrite_o),
        .writeReg_o       (writeReg_o),
        .fwd_valid_o      (fwd_valid_o),
        .stall_cnt_o      (stall_cnt_o),
        .stall_cnt_clr    (stall_cnt_clr)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1ns past it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic beat(input logic m2r, input logic [63:0] mem, input logic [63:0] alu,
                        input logic rw, input logic [AW-1:0] wr);
        in_valid          = 1'b1;
        mem2Reg_i         = m2r;
        memRead_dataOut_i = mem;
        regData_i         = alu;
        regWrite_i        = rw;
        writeReg_i        = wr;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        memRead_dataOut_i = '0; regData_i = '0; mem2Reg_i = 1'b0;
        regWrite_i = 1'b0; writeReg_i = '0; stall_cnt_clr = 1'b0;

        // Reset state
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_wbdata", wbData_o, 64'd0);
        check("rst_regwrite", 64'(regWrite_o), 64'd0);
        check("rst_writereg", 64'(writeReg_o), 64'd0);
        check("rst_fwd", 64'(fwd_valid_o), 64'd0);
        check("rst_stall", 64'(stall_cnt_o), 64'd0);
        reset = 1'b1;

        // Single beat, memory data selected
        out_ready = 1'b1;
        beat(1'b1, 64'hDEAD, 64'h1234, 1'b1, 5'd7);
        step();
        check("single_valid", 64'(out_valid), 64'd1);
        check("single_wb", wbData_o, 64'hDEAD);
        check("single_wr", 64'(writeReg_o), 64'd7);
        check("single_rw", 64'(regWrite_o), 64'd1);
        check("single_fwd", 64'(fwd_valid_o), 64'd1);
        in_valid = 1'b0;
        step();
        check("single_gone", 64'(out_valid), 64'd0);
        check("single_rw_gated", 64'(regWrite_o), 64'd0);

        // Streaming 8 back-to-back beats
        for (int i = 1; i <= 8; i++) begin
            beat(1'b0, 64'hFFFF, 64'(i), 1'b1, AW'(i));
            check("stream_in_ready", 64'(in_ready), 64'd1);
            step();
            check("stream_valid", 64'(out_valid), 64'd1);
            check("stream_wb", wbData_o, 64'(i));
        end
        in_valid = 1'b0;
        step();
        check("stream_end", 64'(out_valid), 64'd0);
        check("stream_stall", 64'(stall_cnt_o), 64'd0);

        // Back-pressure: A, B accepted, C waits
        out_ready = 1'b0;
        beat(1'b0, 64'h0, 64'hA0, 1'b1, 5'd1);
        step();
        check("bp_a_ready", 64'(in_ready), 64'd1);
        check("bp_a_wb", wbData_o, 64'hA0);
        check("bp_a_stall", 64'(stall_cnt_o), 64'd0);
        beat(1'b1, 64'hB0, 64'h99, 1'b1, 5'd2);
        step();
        check("bp_b_ready", 64'(in_ready), 64'd0);
        check("bp_b_wb", wbData_o, 64'hA0);
        check("bp_b_stall", 64'(stall_cnt_o), 64'd1);
        // memRead changes after B was captured; B must keep 0xB0
        beat(1'b0, 64'h77, 64'hC0, 1'b0, 5'd3);
        step();
        check("bp_c_ready", 64'(in_ready), 64'd0);
        check("bp_hold_wb", wbData_o, 64'hA0);
        check("bp_hold_wr", 64'(writeReg_o), 64'd1);
        check("bp_stall2", 64'(stall_cnt_o), 64'd2);
        step();
        check("bp_stall3", 64'(stall_cnt_o), 64'd3);
        out_ready = 1'b1;
        step();
        check("bp_out_b", wbData_o, 64'hB0);
        check("bp_out_b_wr", 64'(writeReg_o), 64'd2);
        check("bp_ready_back", 64'(in_ready), 64'd1);
        check("bp_stall_hold", 64'(stall_cnt_o), 64'd3);
        step();
        in_valid = 1'b0;
        check("bp_out_c", wbData_o, 64'hC0);
        check("bp_out_c_rw", 64'(regWrite_o), 64'd0);
        check("bp_out_c_valid", 64'(out_valid), 64'd1);
        step();
        check("bp_drained", 64'(out_valid), 64'd0);

        // Zero-register guard
        beat(1'b0, 64'h0, 64'h55, 1'b1, 5'd0);
        step();
        in_valid = 1'b0;
        check("zr_valid", 64'(out_valid), 64'd1);
        check("zr_rw", 64'(regWrite_o), 64'd0);
        check("zr_fwd", 64'(fwd_valid_o), 64'd0);
        check("zr_wb", wbData_o, 64'h55);
        step();

        // Flush while FULL with a simultaneous beat
        out_ready = 1'b0;
        beat(1'b0, 64'h0, 64'hD0, 1'b1, 5'd4);
        step();
        beat(1'b0, 64'h0, 64'hE0, 1'b1, 5'd5);
        step();
        check("fl_full", 64'(in_ready), 64'd0);
        beat(1'b0, 64'h0, 64'hF0, 1'b1, 5'd6);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_ready", 64'(in_ready), 64'd1);
        check("fl_rw", 64'(regWrite_o), 64'd0);
        check("fl_fwd", 64'(fwd_valid_o), 64'd0);
        out_ready = 1'b1;
        step();
        check("fl_still_empty", 64'(out_valid), 64'd0);
        check("fl_stall", 64'(stall_cnt_o), 64'd5);

        // Async reset mid-FULL
        out_ready = 1'b0;
        beat(1'b0, 64'h0, 64'h11, 1'b1, 5'd8);
        step();
        beat(1'b1, 64'h22, 64'h0, 1'b1, 5'd9);
        step();
        in_valid = 1'b0;
        check("ar_full", 64'(in_ready), 64'd0);
        check("ar_stall_pre", 64'(stall_cnt_o), 64'd6);
        #2;
        reset = 1'b0;
        #1;
        check("ar_valid", 64'(out_valid), 64'd0);
        check("ar_wb", wbData_o, 64'd0);
        check("ar_wr", 64'(writeReg_o), 64'd0);
        check("ar_rw", 64'(regWrite_o), 64'd0);
        check("ar_fwd", 64'(fwd_valid_o), 64'd0);
        check("ar_stall", 64'(stall_cnt_o), 64'd0);
        check("ar_ready", 64'(in_ready), 64'd1);
        reset = 1'b1;
        step();
        check("ar_discard", 64'(out_valid), 64'd0);

        // Stall counter saturation (4 bits) and clear
        beat(1'b0, 64'h0, 64'h33, 1'b1, 5'd10);
        step();
        in_valid = 1'b0;
        check("sat_start", 64'(stall_cnt_o), 64'd0);
        repeat (15) step();
        check("sat_15", 64'(stall_cnt_o), 64'd15);
        repeat (6) step();
        check("sat_hold", 64'(stall_cnt_o), 64'd15);
        check("sat_wb_stable", wbData_o, 64'h33);
        stall_cnt_clr = 1'b1;
        step();
        check("clr_zero", 64'(stall_cnt_o), 64'd0);
        stall_cnt_clr = 1'b0;
        step();
        check("clr_resume", 64'(stall_cnt_o), 64'd1);
        out_ready = 1'b1;
        step();
        check("sat_drained", 64'(out_valid), 64'd0);
        check("sat_final", 64'(stall_cnt_o), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_memwb_elastic.md
Name: pipe_memwb_elastic

Overview:
Parametrised MEM/WB pipeline stage with a valid/ready handshake and a 2-entry skid buffer. Back-pressure from writeback does not need a combinational stall path to MEM. The writeback mux (memory data vs ALU data) is resolved at capture time, so WB receives a single registered result. The block also provides a forwarding tap for EX hazard logic, a synchronous flush, and a saturating stall counter for debug.

Parameters:
DATA_WIDTH, 64, width of memory-read data, ALU data and writeback result
REGFILE_ADDRESS_WIDTH, 5, destination register index width
ZERO_REG_GUARD, 1, when 1, writes targeting register 0 are captured with regWrite forced to 0
STALL_CNT_WIDTH, 16, width of the saturating stall counter

Ports:
clock  in  1  stage clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous flush; invalidates both entries
in_valid  in  1  MEM beat valid
in_ready  out  1  stage can accept a beat
memRead_dataOut_i  in  DATA_WIDTH  data memory read result
regData_i  in  DATA_WIDTH  ALU/pass-through result
mem2Reg_i  in  1  1 selects memRead_dataOut_i as the writeback value
regWrite_i  in  1  beat writes the register file
writeReg_i  in  REGFILE_ADDRESS_WIDTH  destination register
out_valid  out  1  head entry valid toward WB
out_ready  in  1  WB consumes the head entry
wbData_o  out  DATA_WIDTH  resolved writeback value of the head entry
regWrite_o  out  1  head entry write enable; 0 whenever out_valid=0
writeReg_o  out  REGFILE_ADDRESS_WIDTH  head entry destination
fwd_valid_o  out  1  out_valid & regWrite_o; forwarding tap is usable
stall_cnt_o  out  STALL_CNT_WIDTH  saturating count of out_valid & !out_ready cycles
stall_cnt_clr  in  1  synchronous clear of stall_cnt_o

Behaviour:
- Reset (async, reset=0): both entries invalid; wbData_o=0, regWrite_o=0, writeReg_o=0, out_valid=0, fwd_valid_o=0, stall_cnt_o=0, in_ready=1 (once the state is EMPTY). Reset asserted mid-transfer discards all buffered beats.
- Entry contents: {wb = mem2Reg_i ? memRead_dataOut_i : regData_i, rw = regWrite_i & !(ZERO_REG_GUARD & writeReg_i==0), wr = writeReg_i}. The mux is evaluated in the capture cycle only.
- Handshake definitions: accept = in_valid & in_ready; drain = out_valid & out_ready.
- in_ready = (state != FULL). It is driven from registers only and has no combinational path from out_ready.
- Output paths: out_valid, wbData_o and writeReg_o are driven directly from the head (main) entry. regWrite_o = main.rw & out_valid.
- State machine (states EMPTY, ONE, FULL):
  - EMPTY: accept -> ONE, main<=in.
  - ONE, accept & drain -> ONE, main<=in.
  - ONE, accept & !drain -> FULL, skid<=in.
  - ONE, !accept & drain -> EMPTY.
  - ONE, neither -> hold.
  - FULL: drain -> ONE, main<=skid. No accept is possible (in_ready=0). Otherwise hold.
- Latency: 1 cycle from accept to out_valid when EMPTY. Ordering is strictly FIFO, with no loss and no duplication.
- Holding: while out_valid=1 and out_ready=0, all head outputs are stable.
- Flush: highest priority, next state EMPTY. Any beat handshaked in the flush cycle is discarded, and so is a drain in the same cycle (WB must gate on its own flush). Data registers may keep stale values; valid bits are what matter.
- Stall counter: increments by 1 on each cycle with out_valid & !out_ready and saturates at all-ones. stall_cnt_clr has priority over increment. The counter is not affected by flush.
- Width rules: wbData_o is DATA_WIDTH with no truncation. writeReg_o is REGFILE_ADDRESS_WIDTH bits exactly.

Test Plan:
- Reset, then a single beat: in_valid=1, mem2Reg=1, memRead=0xDEAD, regData=0x1234, writeReg=7, regWrite=1, out_ready=1 -> next cycle out_valid=1, wbData_o=0xDEAD, writeReg_o=7, regWrite_o=1, fwd_valid_o=1; following cycle out_valid=0.
- Streaming: 8 back-to-back beats carrying regData 1..8, mem2Reg=0, out_ready=1 -> in_ready stays 1; WB sees 1..8 on 8 consecutive cycles.
- Back-pressure: out_ready=0 while 3 beats A, B, C are offered -> A and B accepted, in_ready=0 during C; stall_cnt_o increments each held cycle. Release out_ready -> output order A, B, C; C accepted once in_ready=1.
- Zero-register guard: a beat with writeReg=0, regWrite=1 -> out_valid=1, regWrite_o=0, fwd_valid_o=0.
- Flush while FULL (2 entries held), with in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1; no flushed or simultaneous beat ever appears at the output.
- Reset and counter checks:
  - Reset asserted asynchronously mid-FULL -> all outputs 0 immediately, without waiting for a clock edge.
  - Hold a stall for 2^STALL_CNT_WIDTH+5 cycles with a reduced width of 4 -> stall_cnt_o saturates at 15.
  - stall_cnt_clr=1 -> stall_cnt_o=0 on the next cycle.
